// File: rtl/rotation_pkg.sv
// Shared types and default constants for the rotation synchronizer slice.
package rotation_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ARMED    = 2'd1,
      LOCKED   = 2'd2
   } rot_state_t;

   localparam int DEF_NB_SLICES     = 128;
   localparam int DEF_COUNTER_WIDTH = 32;
   localparam int DEF_MIN_PERIOD    = 66_000;
   localparam int DEF_TIMEOUT       = 66_000_000;

endpackage

// File: rtl/hall_edge_detect.sv
// Two-flop synchronizer on the raw hall pin plus a registered falling-edge
// detector; o_hall_event is high for exactly one cycle per magnet arrival.
module hall_edge_detect (
   input  logic clk,
   input  logic nrst,
   input  logic i_hall_sensor,
   output logic o_hall_event
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_event;

   // Idle level of the sensor is high, so the chain resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
         r_event <= 1'b0;
      end else begin
         r_sync1 <= i_hall_sensor;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_event <= r_sync3 & ~r_sync2;
      end
   end

   assign o_hall_event = r_event;

endmodule

// File: rtl/rotation_sync.sv
// Measures the hall-sensor revolution period and slices each revolution into
// NB_SLICES equal parts; position_sync feeds driver_controller and column_mux.
module rotation_sync
   import rotation_pkg::*;
#(
   parameter int NB_SLICES     = DEF_NB_SLICES,
   parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
   parameter int MIN_PERIOD    = DEF_MIN_PERIOD,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         hall_sensor,
   output logic                         position_sync,
   output logic [$clog2(NB_SLICES)-1:0] slice_cnt,
   output logic [COUNTER_WIDTH-1:0]     rotation_period,
   output logic                         locked
);

   localparam int SLICE_W = $clog2(NB_SLICES);
   localparam logic [COUNTER_WIDTH-1:0] C_MIN_PERIOD = COUNTER_WIDTH'(MIN_PERIOD);
   localparam logic [COUNTER_WIDTH-1:0] C_TIMEOUT    = COUNTER_WIDTH'(TIMEOUT);
   localparam logic [COUNTER_WIDTH-1:0] C_ONE        = COUNTER_WIDTH'(1);
   localparam logic [SLICE_W-1:0]       C_SLICE_MAX  = SLICE_W'(NB_SLICES - 1);
   localparam logic [SLICE_W-1:0]       C_SLICE_ONE  = SLICE_W'(1);

   rot_state_t               r_state;
   logic [COUNTER_WIDTH-1:0] r_period_cnt;
   logic [COUNTER_WIDTH-1:0] r_slice_timer;
   logic [COUNTER_WIDTH-1:0] r_rotation_period;
   logic [SLICE_W-1:0]       r_slice_cnt;
   logic                     r_position_sync;
   logic                     r_locked;

   logic                     w_hall_event;
   logic [COUNTER_WIDTH-1:0] w_cnt_inc;
   logic [COUNTER_WIDTH-1:0] w_slice_period;
   logic                     w_timeout;
   logic                     w_accept;
   logic                     w_resync;
   logic                     w_slice_wrap;

   hall_edge_detect u_hall_edge_detect (
      .clk           (clk),
      .nrst          (nrst),
      .i_hall_sensor (hall_sensor),
      .o_hall_event  (w_hall_event)
   );

   // Events closer than MIN_PERIOD are treated as sensor glitches once a period is being tracked.
   assign w_cnt_inc      = r_period_cnt + C_ONE;
   assign w_timeout      = (r_period_cnt == C_TIMEOUT);
   assign w_accept       = w_hall_event && ((r_state == UNLOCKED) || (w_cnt_inc >= C_MIN_PERIOD));
   assign w_resync       = w_accept && !w_timeout && (r_state != UNLOCKED);
   assign w_slice_period = r_rotation_period >> SLICE_W;
   assign w_slice_wrap   = (r_slice_timer == (w_slice_period - C_ONE));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_period_cnt <= '0;
      end else if (w_accept) begin
         r_period_cnt <= '0;
      end else if (!w_timeout) begin
         r_period_cnt <= w_cnt_inc;
      end
   end

   // A timeout wins over the FSM; an event in that same cycle just re-arms.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= UNLOCKED;
      end else if (w_timeout) begin
         r_state <= w_accept ? ARMED : UNLOCKED;
      end else if (w_accept) begin
         case (r_state)
            UNLOCKED: r_state <= ARMED;
            default:  r_state <= LOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rotation_period <= '0;
      end else if (w_resync) begin
         r_rotation_period <= w_cnt_inc;
      end
   end

   // Resync has priority over a coincident slice wrap; slice_cnt parks at the last slice.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_slice_timer   <= '0;
         r_slice_cnt     <= '0;
         r_position_sync <= 1'b0;
         r_locked        <= 1'b0;
      end else if (w_resync) begin
         r_slice_timer   <= '0;
         r_slice_cnt     <= '0;
         r_position_sync <= 1'b1;
         r_locked        <= 1'b1;
      end else if (w_timeout || (r_state != LOCKED)) begin
         r_slice_timer   <= '0;
         r_slice_cnt     <= '0;
         r_position_sync <= 1'b0;
         r_locked        <= 1'b0;
      end else begin
         r_position_sync <= 1'b0;
         if (w_slice_wrap) begin
            r_slice_timer <= '0;
            if (r_slice_cnt != C_SLICE_MAX) begin
               r_slice_cnt     <= r_slice_cnt + C_SLICE_ONE;
               r_position_sync <= 1'b1;
            end
         end else begin
            r_slice_timer <= r_slice_timer + C_ONE;
         end
      end
   end

   assign position_sync   = r_position_sync;
   assign slice_cnt       = r_slice_cnt;
   assign rotation_period = r_rotation_period;
   assign locked          = r_locked;

endmodule
